// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU among N_REQ requesters.
// Round-robin grant in IDLE, the operation runs in EXEC, and the registered
// result/flags are returned in RESP until the owner takes them.
// The rotation pointer advances only when a response completes.
// Optional build macro: ALU_ARB_BYPASS_EN. When it is defined, EXEC is removed:
// the winner's request fields drive alu_* combinationally in IDLE, and the
// result is captured on the accept edge.
module alu_arbiter #(
    parameter int N_REQ = 2,
    parameter int SIZE  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [4*N_REQ-1:0]    req_funct,
    input  logic [SIZE*N_REQ-1:0] req_a,
    input  logic [SIZE*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [SIZE-1:0]       rsp_result,
    output logic [5:0]            rsp_flags,
    output logic [3:0]            alu_funct,
    output logic [SIZE-1:0]       alu_a,
    output logic [SIZE-1:0]       alu_b,
    input  logic [SIZE-1:0]       alu_result,
    input  logic [5:0]            alu_flags
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [PW-1:0]     ptr_r, ptr_s;
    logic [PW-1:0]     owner_r, owner_s;
    logic [PW-1:0]     winner_s;
    logic [PW:0]       idx_s;
    logic              any_s;
    logic              accept_s;
    logic              capture_s;
    logic [N_REQ-1:0]  req_ready_s;
    logic [N_REQ-1:0]  rsp_valid_s;
    logic [N_REQ-1:0]  rsp_valid_r;
    logic [3:0]        win_funct_s;
    logic [SIZE-1:0]   win_a_s;
    logic [SIZE-1:0]   win_b_s;
    logic [3:0]        op_funct_r;
    logic [SIZE-1:0]   op_a_r;
    logic [SIZE-1:0]   op_b_r;
    logic [SIZE-1:0]   rsp_result_r;
    logic [5:0]        rsp_flags_r;

    // Round-robin search: walk from ptr+N-1 down to ptr so the last hit is the first valid at/after ptr
    always_comb begin
        any_s    = 1'b0;
        winner_s = '0;
        idx_s    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx_s    = {1'b0, ptr_r} + (PW+1)'(k);
            idx_s    = (idx_s >= (PW+1)'(N_REQ)) ? (idx_s - (PW+1)'(N_REQ)) : idx_s;
            any_s    = any_s | req_valid[idx_s[PW-1:0]];
            winner_s = req_valid[idx_s[PW-1:0]] ? idx_s[PW-1:0] : winner_s;
        end
    end

    // Select the winning requester's funct/operands
    always_comb begin
        win_funct_s = 4'd0;
        win_a_s     = '0;
        win_b_s     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_funct_s = (winner_s == PW'(i)) ? req_funct[4*i +: 4]       : win_funct_s;
            win_a_s     = (winner_s == PW'(i)) ? req_a[SIZE*i +: SIZE]     : win_a_s;
            win_b_s     = (winner_s == PW'(i)) ? req_b[SIZE*i +: SIZE]     : win_b_s;
        end
    end

    // Next-state, grant and capture decisions
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        owner_s   = owner_r;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    accept_s = 1'b1;
                    owner_s  = winner_s;
`ifdef ALU_ARB_BYPASS_EN
                    capture_s = 1'b1;
                    state_s   = RESP;
`else
                    capture_s = 1'b0;
                    state_s   = EXEC;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                capture_s = 1'b1;
                state_s   = RESP;
            end
            RESP: begin
                if (rsp_ready[owner_r]) begin
                    ptr_s   = (owner_r == PW'(N_REQ - 1)) ? '0 : (owner_r + PW'(1));
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // One-hot grant (IDLE only) and next-cycle response-valid decode
    always_comb begin
        req_ready_s = '0;
        rsp_valid_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready_s[i] = accept_s && (winner_s == PW'(i));
            rsp_valid_s[i] = (state_s == RESP) && (owner_s == PW'(i));
        end
    end

    // Control state, latched operation and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            ptr_r        <= '0;
            owner_r      <= '0;
            op_funct_r   <= 4'd0;
            op_a_r       <= '0;
            op_b_r       <= '0;
            rsp_result_r <= '0;
            rsp_flags_r  <= 6'd0;
            rsp_valid_r  <= '0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            owner_r     <= owner_s;
            rsp_valid_r <= rsp_valid_s;
            if (accept_s) begin
                op_funct_r <= win_funct_s;
                op_a_r     <= win_a_s;
                op_b_r     <= win_b_s;
            end
            if (capture_s) begin
                rsp_result_r <= alu_result;
                rsp_flags_r  <= alu_flags;
            end
        end
    end

    // Grant is combinational; forced low while reset is asserted
    assign req_ready  = req_ready_s & {N_REQ{rst_n}};
    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = rsp_result_r;
    assign rsp_flags  = rsp_flags_r;

`ifdef ALU_ARB_BYPASS_EN
    // In IDLE with a winner, the ALU sees the request directly; otherwise the last op holds
    assign alu_funct = (rst_n && accept_s) ? win_funct_s : op_funct_r;
    assign alu_a     = (rst_n && accept_s) ? win_a_s     : op_a_r;
    assign alu_b     = (rst_n && accept_s) ? win_b_s     : op_b_r;
`else
    assign alu_funct = op_funct_r;
    assign alu_a     = op_a_r;
    assign alu_b     = op_b_r;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter (N_REQ=3, SIZE=64) with an attached reference ALU.
// Directed scenarios with literal expectations are followed by randomized traffic.
// A transaction-level model is checked against the DUT on every falling edge.
module tb_alu_arbiter;

    localparam int N = 3;
    localparam int W = 64;
`ifdef ALU_ARB_BYPASS_EN
    localparam int LAT = 1;
    localparam bit BYP = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [4*N-1:0]   req_funct;
    logic [W*N-1:0]   req_a, req_b;
    logic [W-1:0]     rsp_result, alu_a, alu_b, alu_result;
    logic [5:0]       rsp_flags, alu_flags;
    logic [3:0]       alu_funct;

    int total = 0;
    int bad   = 0;

    // model state
    bit           m_busy;
    int           m_owner, m_age, m_ptr;
    logic [3:0]   m_f;
    logic [W-1:0] m_a, m_b;
    logic [69:0]  m_last;
    logic [N-1:0] hs;

    always #5 clk = ~clk;

    alu_arbiter #(.N_REQ(N), .SIZE(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_flags(alu_flags)
    );

    // reference ALU: returns {ovf,neg,zero,eq,gt,lt,result}
    function automatic logic [69:0] alu_ref(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic ov;
        ov = 1'b0;
        case (f)
            4'd0: begin r = a + b; ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
            4'd1: begin r = a - b; ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            default: r = a;
        endcase
        return {ov, r[W-1], (r == '0), (a == b), ($signed(a) > $signed(b)), ($signed(a) < $signed(b)), r};
    endfunction

    assign {alu_flags, alu_result} = alu_ref(alu_funct, alu_a, alu_b);

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int dec(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v == N'(1 << k)) return k;
        end
        return 9;
    endfunction

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        req_funct[4*i +: 4] = f;
        req_a[W*i +: W]     = a;
        req_b[W*i +: W]     = b;
    endtask

    task automatic new_op(input int i);
        logic [W-1:0] a, b;
        a = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: b = a;
            1: b = W'($urandom_range(0, 15));
            2: b = {1'b1, a[W-2:0]};
            default: b = {$urandom, $urandom};
        endcase
        set_op(i, 4'($urandom_range(0, 5)), a, b);
    endtask

    // after an accept edge, count falling edges until a response shows
    task automatic wait_rsp(input string nm);
        int n;
        n = 0;
        while (n < 8) begin
            @(negedge clk);
            n++;
            if (rsp_valid != '0) break;
        end
        chk(nm, n, LAT);
    endtask

    // compare process: check DUT against the model, then advance the model
    initial begin
        int w;
        logic [N-1:0] er, ev;
        logic [3:0] ef;
        logic [W-1:0] ea, eb;
        m_busy = 0; m_owner = 0; m_age = 0; m_ptr = 0;
        m_f = '0; m_a = '0; m_b = '0; m_last = '0; hs = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_req_ready", req_ready, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_result", rsp_result, 0);
                chk("rst_flags", rsp_flags, 0);
                chk("rst_alu_a", alu_a, 0);
                m_busy = 0; m_owner = 0; m_age = 0; m_ptr = 0;
                m_f = '0; m_a = '0; m_b = '0; m_last = '0; hs = '0;
            end else begin
                w  = m_busy ? -1 : pick(req_valid, m_ptr);
                er = (w >= 0) ? N'(1 << w) : '0;
                ev = (m_busy && m_age >= LAT) ? N'(1 << m_owner) : '0;
                ef = m_f; ea = m_a; eb = m_b;
                if (BYP && w >= 0) begin
                    ef = req_funct[4*w +: 4];
                    ea = req_a[W*w +: W];
                    eb = req_b[W*w +: W];
                end
                chk("req_ready", req_ready, er);
                chk("rsp_valid", rsp_valid, ev);
                chk("rsp_result", rsp_result, m_last[63:0]);
                chk("rsp_flags", rsp_flags, m_last[69:64]);
                chk("alu_funct", alu_funct, ef);
                chk("alu_a", alu_a, ea);
                chk("alu_b", alu_b, eb);
                hs = req_valid & req_ready;
                if (w >= 0) begin
                    m_busy = 1; m_owner = w; m_age = 1;
                    m_f = req_funct[4*w +: 4]; m_a = req_a[W*w +: W]; m_b = req_b[W*w +: W];
                    if (m_age == LAT) m_last = alu_ref(m_f, m_a, m_b);
                end else if (m_busy && m_age >= LAT) begin
                    if (rsp_ready[m_owner]) begin
                        m_busy = 0;
                        m_ptr  = (m_owner + 1) % N;
                    end
                end else if (m_busy) begin
                    m_age++;
                    if (m_age == LAT) m_last = alu_ref(m_f, m_a, m_b);
                end
            end
        end
    end

    // stimulus
    initial begin
        int g[$];
        int n;
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
        req_funct = '0; req_a = '0; req_b = '0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();

        // reset mid-operation takes effect immediately
        set_op(0, 4'd0, 64'd3, 64'd4);
        req_valid = 3'b001;
        cyc();
        req_valid = '0;
        chk("t1_alu_a_before", alu_a, 64'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_req_ready", req_ready, 3'b000);
        chk("t1_rsp_valid", rsp_valid, 3'b000);
        chk("t1_alu_a", alu_a, 64'd0);
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();

        // single SUM on requester 0
        set_op(0, 4'd0, 64'd5, 64'd7);
        req_valid = 3'b001;
        rsp_ready = 3'b111;
        @(negedge clk);
        chk("t2_req_ready", req_ready, 3'b001);
        cyc();
        req_valid = '0;
        wait_rsp("t2_latency");
        chk("t2_rsp_valid", rsp_valid, 3'b001);
        chk("t2_result", rsp_result, 64'd12);
        chk("t2_flags", rsp_flags, 6'b000001);
        cyc();

        // both valid from ptr=0: grants alternate 0,1,0,1
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        set_op(0, 4'd4, 64'hF0F0, 64'h0FF0);
        set_op(1, 4'd2, 64'hFFFF, 64'h1234);
        req_valid = 3'b011;
        n = 0;
        while (g.size() < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (req_ready != '0) g.push_back(dec(req_ready));
        end
        chk("t3_grant_count", g.size(), 4);
        for (int k = 0; k < g.size(); k++) chk("t3_grant_order", g[k], k % 2);
        cyc();
        req_valid = '0;
        repeat (5) cyc();

        // ptr=2 with req_valid=011 wraps to requester 0, then requester 1 SUB overflow
        set_op(0, 4'd0, 64'd1, 64'd1);
        set_op(1, 4'd1, 64'h8000_0000_0000_0000, 64'd1);
        req_valid = 3'b011;
        @(negedge clk);
        chk("t6_wrap_winner", req_ready, 3'b001);
        cyc();
        req_valid = 3'b010;
        wait_rsp("t6_latency");
        chk("t6_result", rsp_result, 64'd2);
        chk("t6_flags", rsp_flags, 6'b000100);
        cyc();
        @(negedge clk);
        chk("t4_req_ready", req_ready, 3'b010);
        cyc();
        req_valid = '0;
        wait_rsp("t4_latency");
        chk("t4_rsp_valid", rsp_valid, 3'b010);
        chk("t4_result", rsp_result, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("t4_flags", rsp_flags, 6'b100001);
        cyc();

        // response stall: held result, no grants despite all valid
        rsp_ready = 3'b000;
        set_op(2, 4'd0, 64'd10, 64'd20);
        req_valid = 3'b100;
        @(negedge clk);
        chk("t5_req_ready", req_ready, 3'b100);
        cyc();
        req_valid = 3'b111;
        wait_rsp("t5_latency");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t5_hold_valid", rsp_valid, 3'b100);
            chk("t5_hold_result", rsp_result, 64'd30);
            chk("t5_no_grant", req_ready, 3'b000);
        end
        cyc();
        rsp_ready = 3'b111;
        cyc();
        @(negedge clk);
        chk("t5_next_winner", req_ready, 3'b001);
        cyc();
        req_valid = '0;
        repeat (6) cyc();

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            cyc();
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
            end
            rsp_ready = N'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    new_op(i);
                    req_valid[i] = 1'($urandom_range(0, 1));
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        new_op(i);
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        rst_n = 1'b1;
        req_valid = '0;
        rsp_ready = 3'b111;
        repeat (8) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
